// File: rtl/vdp_pkg.sv
// Default raster timing constants for the VDP video path (NTSC/PAL totals,
// sync widths, active windows, colour depth). No logic, no latency.
// Consumers take these as parameter defaults and may override them.
package vdp_pkg;

  localparam int VDP_COLOR_W      = 6;
  localparam int VDP_CLK_DIV      = 2;
  localparam int VDP_H_TOTAL      = 342;
  localparam int VDP_H_PRESET     = 36;
  localparam int VDP_H_SYNC_W     = 20;
  localparam int VDP_H_ACT_START  = 60;
  localparam int VDP_H_ACT_END    = 340;
  localparam int VDP_V_TOTAL_NTSC = 262;
  localparam int VDP_V_TOTAL_PAL  = 313;
  localparam int VDP_V_SYNC_W     = 4;
  localparam int VDP_V_ACT_START  = 8;

  function automatic int vdp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vdp_pixel_tick.sv
// Pixel-rate divider: counts qualified ena cycles, tick on the last phase.
// Latency: tick is combinational from the phase register and ena.
// Backpressure: none; ena low freezes the phase and suppresses tick.
// Ports: clk, RESET (sync, active high), ena -> tick.
module vdp_pixel_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic RESET,
  input  logic ena,
  output logic tick
);

  localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase_q, phase_d;

  // With CLK_DIV=1 PH_LAST is 0 and phase never leaves 0, so every ena is a tick.
  assign tick = ena && (phase_q == PH_LAST);

  always_comb begin
    phase_d = phase_q;
    if (ena) begin
      phase_d = tick ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/vdp_raster_timing.sv
// Raster timing generator + registered/blanked RGB output stage for the VDP path.
// Latency: syncs/blank/RGB lag the counters by 1 ena cycle; hcnt/vcnt/line/frame are raw.
// Backpressure: none; ena low freezes all state and forces line_o/frame_o to 0.
// Ports: clk, RESET, ena, pal_i, r_i/g_i/b_i in; HS, VS, R/G/B, blank_o, hcnt_o, vcnt_o,
// line_o, frame_o out. Optional VDP_RASTER_PASSTHRU_EN adds passthru_i, ext_hs_n_i,
// ext_vs_n_i to route external syncs and unblanked colour to the pins.
module vdp_raster_timing
  import vdp_pkg::*;
#(
  parameter int COLOR_W      = VDP_COLOR_W,
  parameter int CLK_DIV      = VDP_CLK_DIV,
  parameter int H_TOTAL      = VDP_H_TOTAL,
  parameter int H_PRESET     = VDP_H_PRESET,
  parameter int H_SYNC_W     = VDP_H_SYNC_W,
  parameter int H_ACT_START  = VDP_H_ACT_START,
  parameter int H_ACT_END    = VDP_H_ACT_END,
  parameter int V_TOTAL_NTSC = VDP_V_TOTAL_NTSC,
  parameter int V_TOTAL_PAL  = VDP_V_TOTAL_PAL,
  parameter int V_SYNC_W     = VDP_V_SYNC_W,
  parameter int V_ACT_START  = VDP_V_ACT_START,
  localparam int HW          = $clog2(H_TOTAL),
  localparam int VW          = $clog2(vdp_max(V_TOTAL_NTSC, V_TOTAL_PAL))
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               ena,
  input  logic               pal_i,
  input  logic [COLOR_W-1:0] r_i,
  input  logic [COLOR_W-1:0] g_i,
  input  logic [COLOR_W-1:0] b_i,
`ifdef VDP_RASTER_PASSTHRU_EN
  input  logic               passthru_i,
  input  logic               ext_hs_n_i,
  input  logic               ext_vs_n_i,
`endif
  output logic               HS,
  output logic               VS,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               blank_o,
  output logic [HW-1:0]      hcnt_o,
  output logic [VW-1:0]      vcnt_o,
  output logic               line_o,
  output logic               frame_o
);

  localparam logic [HW-1:0] H_RST = HW'(H_TOTAL - H_PRESET);

  logic               tick;
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [VW-1:0]      vcnt_q, vcnt_d;
  logic               pal_q, pal_d;
  logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               line_wrap, frame_wrap, blank_c;
  int                 v_last;

  vdp_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .RESET(RESET),
    .ena  (ena),
    .tick (tick)
  );

  always_comb begin
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    pal_d      = pal_q;
    // Frame length is fixed by the PAL mode latched at the previous frame wrap.
    v_last     = pal_q ? (V_TOTAL_PAL - 1) : (V_TOTAL_NTSC - 1);
    line_wrap  = tick && (int'(hcnt_q) == H_TOTAL - 1);
    frame_wrap = line_wrap && (int'(vcnt_q) == v_last);
    if (tick) begin
      if (line_wrap) begin
        hcnt_d = '0;
        if (frame_wrap) begin
          vcnt_d = '0;
          pal_d  = pal_i;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end

    // Output stage works from the pre-edge counters and runs on every ena cycle.
    blank_c = (int'(vcnt_q) < V_ACT_START) || (int'(hcnt_q) < H_ACT_START) ||
              (int'(hcnt_q) >= H_ACT_END);
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (ena) begin
      blank_d = blank_c;
`ifdef VDP_RASTER_PASSTHRU_EN
      if (passthru_i) begin
        hs_d = ext_hs_n_i;
        vs_d = ext_vs_n_i;
        r_d  = r_i;
        g_d  = g_i;
        b_d  = b_i;
      end else
`endif
      begin
        hs_d = !(int'(hcnt_q) < H_SYNC_W);
        vs_d = !(int'(vcnt_q) < V_SYNC_W);
        r_d  = blank_c ? '0 : r_i;
        g_d  = blank_c ? '0 : g_i;
        b_d  = blank_c ? '0 : b_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      hcnt_q  <= H_RST;
      vcnt_q  <= '0;
      pal_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pal_q   <= pal_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  // Strobes are combinational on the wrapping tick; reset masks them immediately.
  assign line_o  = line_wrap && !RESET;
  assign frame_o = frame_wrap && !RESET;
  assign hcnt_o  = hcnt_q;
  assign vcnt_o  = vcnt_q;
  assign HS      = hs_q;
  assign VS      = vs_q;
  assign blank_o = blank_q;
  assign R       = r_q;
  assign G       = g_q;
  assign B       = b_q;

endmodule

// File: tb/tb_vdp_raster_timing.sv
module tb_vdp_raster_timing;

  localparam int CW  = 6;
  localparam int TD  = 2;
  localparam int TH  = 20;
  localparam int TPR = 4;
  localparam int THS = 3;
  localparam int TAS = 5;
  localparam int TAE = 18;
  localparam int TVN = 8;
  localparam int TVP = 10;
  localparam int TVS = 2;
  localparam int TVA = 3;
  localparam int HWT = $clog2(TH);
  localparam int VWT = $clog2((TVN > TVP) ? TVN : TVP);

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          ena = 1'b0;
  logic          pal_i = 1'b0;
  logic [CW-1:0] r_i = '0, g_i = '0, b_i = '0;
  logic          HS, VS, blank_o, line_o, frame_o;
  logic [CW-1:0] R, G, B;
  logic [HWT-1:0] hcnt_o;
  logic [VWT-1:0] vcnt_o;

  always #5 clk = ~clk;

  vdp_raster_timing #(
    .COLOR_W(CW), .CLK_DIV(TD), .H_TOTAL(TH), .H_PRESET(TPR), .H_SYNC_W(THS),
    .H_ACT_START(TAS), .H_ACT_END(TAE), .V_TOTAL_NTSC(TVN), .V_TOTAL_PAL(TVP),
    .V_SYNC_W(TVS), .V_ACT_START(TVA)
  ) dut (
    .clk(clk), .RESET(RESET), .ena(ena), .pal_i(pal_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
`ifdef VDP_RASTER_PASSTHRU_EN
    .passthru_i(1'b0), .ext_hs_n_i(1'b1), .ext_vs_n_i(1'b1),
`endif
    .HS(HS), .VS(VS), .R(R), .G(G), .B(B), .blank_o(blank_o),
    .hcnt_o(hcnt_o), .vcnt_o(vcnt_o), .line_o(line_o), .frame_o(frame_o)
  );

  typedef struct {
    bit chk_comb;
    int hcnt, vcnt;
    bit line, frame;
    bit hs, vs, blank;
    int r, g, b;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drv_done = 0;
  bit   mon_done = 0;

  // Reference model: position is derived from the number of ena cycles since reset;
  // frames are tracked as a running line offset plus the length of the current frame.
  int m_n, m_fs, m_vtot;
  bit m_valid, m_hs, m_vs, m_blank;
  int m_r, m_g, m_b;

  task automatic step(input bit rst, input bit en, input bit pal, input int r, input int g, input int b);
    exp_t e;
    int   hpos, hc, vc;
    bit   tk, blk;
    @(posedge clk);
    #2;
    RESET = rst; ena = en; pal_i = pal;
    r_i = CW'(r); g_i = CW'(g); b_i = CW'(b);
    hpos = (TH - TPR) + m_n / TD;
    hc   = hpos % TH;
    vc   = hpos / TH - m_fs;
    tk   = en && (m_n % TD == TD - 1);
    e.chk_comb = m_valid;
    e.hcnt  = hc;
    e.vcnt  = vc;
    e.line  = !rst && tk && (hc == TH - 1);
    e.frame = e.line && (vc == m_vtot - 1);
    if (rst) begin
      m_n = 0; m_fs = 0; m_vtot = TVN; m_valid = 1;
      m_hs = 1; m_vs = 1; m_blank = 1; m_r = 0; m_g = 0; m_b = 0;
    end else if (en) begin
      blk     = (vc < TVA) || (hc < TAS) || (hc >= TAE);
      m_blank = blk;
      m_hs    = !(hc < THS);
      m_vs    = !(vc < TVS);
      m_r     = blk ? 0 : (r % 64);
      m_g     = blk ? 0 : (g % 64);
      m_b     = blk ? 0 : (b % 64);
      m_n++;
      if (e.frame) begin
        m_fs  += m_vtot;
        m_vtot = pal ? TVP : TVN;
      end
    end
    e.hs = m_hs; e.vs = m_vs; e.blank = m_blank;
    e.r = m_r; e.g = m_g; e.b = m_b;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Stimulus
  initial begin
    bit pal;
    bit en;
    bit rst;
    m_valid = 0; m_n = 0; m_fs = 0; m_vtot = TVN;
    m_hs = 1; m_vs = 1; m_blank = 1; m_r = 0; m_g = 0; m_b = 0;
    pal = 0;
    repeat (3) step(1, 0, 0, 0, 0, 0);
    // Continuous ena, constant full-scale red through two frames.
    for (int i = 0; i < 700; i++) step(0, 1, 0, 63, $urandom_range(0, 63), $urandom_range(0, 63));
    // Random ena, random colour, occasional PAL flips and resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      en  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0) pal = ~pal;
      step(rst, en, pal, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
    end
    // ena one cycle in three, PAL requested mid-frame.
    for (int i = 0; i < 3600; i++) begin
      if (i == 500) pal = 1;
      step(0, (i % 3) == 0, pal, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
    end
    // Reset mid-frame, then run again.
    step(1, 1, pal, 63, 63, 63);
    for (int i = 0; i < 800; i++) step(0, 1, 0, $urandom_range(0, 63), 63, $urandom_range(0, 63));
    @(posedge clk);
    #2;
    drv_done = 1;
  end

  // Monitor: combinational outputs sampled mid-cycle, registered ones just after the edge.
  initial begin
    exp_t e;
    int   hc, vc;
    bit   ln, fr;
    while (!mon_done) begin
      @(negedge clk);
      hc = int'(hcnt_o); vc = int'(vcnt_o); ln = line_o; fr = frame_o;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (drv_done) mon_done = 1;
        else begin
          errors++;
          $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end
      end else begin
        e = q.pop_front();
        if (e.chk_comb) begin
          chk("hcnt", hc, e.hcnt);
          chk("vcnt", vc, e.vcnt);
          chk("line", int'(ln), int'(e.line));
          chk("frame", int'(fr), int'(e.frame));
        end
        chk("HS", int'(HS), int'(e.hs));
        chk("VS", int'(VS), int'(e.vs));
        chk("blank", int'(blank_o), int'(e.blank));
        chk("R", int'(R), e.r);
        chk("G", int'(G), e.g);
        chk("B", int'(B), e.b);
      end
    end
  end

  initial begin
    fork
      wait (mon_done);
      #2000000;
    join_any
    if (!mon_done) begin
      errors++;
      $display("FAIL timeout: got monitor running expected monitor done");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
